// File: rtl/mem_vector_sequencer.sv
// Serialises a nine-lane vector store or load into single-word data-memory accesses,
// stalling the upstream pipe until the transfer completes.
module mem_vector_sequencer (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteVM,
  input  logic              RegWriteVVM,
  input  logic [31:0]       ALUResultM,
  input  logic signed [8:0] WriteDataVM [0:8],
  input  logic [31:0]       MemRData,
  output logic [31:0]       MemAddr,
  output logic [31:0]       MemWData,
  output logic              MemWE,
  output logic signed [8:0] ReadDataVM [0:8],
  output logic              StallM,
  output logic              VDone
);

  // state     | meaning
  // IDLE      | waiting for a store or load request
  // STORE     | one memory write per lane, lanes 0..8
  // LOAD      | one read address per lane; lane-1 data captured from the previous read
  // LOAD_LAST | capture the read issued for lane 8
  // DONE      | one-cycle completion pulse, pipe released
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STORE     = 3'd1,
    LOAD      = 3'd2,
    LOAD_LAST = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [3:0] LAST_LANE = 4'd8;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_lane;
  logic [31:0]       r_base;
  logic signed [8:0] r_wdata [0:8];
  logic signed [8:0] r_rdata [0:8];

  logic              w_start;
  logic              w_last_lane;
  logic [31:0]       w_lane_addr;
  logic              w_unused_rdata;

  assign w_start        = MemWriteVM | RegWriteVVM;
  assign w_last_lane    = (r_lane == LAST_LANE);
  assign w_lane_addr    = r_base + {28'd0, r_lane};
  assign w_unused_rdata = ^MemRData[31:9];
  assign ReadDataVM     = r_rdata;

  always_comb begin
    w_next_state = r_state;
    MemWE        = 1'b0;
    MemAddr      = 32'd0;
    MemWData     = 32'd0;
    StallM       = 1'b0;
    VDone        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          StallM       = 1'b1;
          w_next_state = MemWriteVM ? STORE : LOAD;
        end
      end
      STORE: begin
        StallM   = 1'b1;
        MemWE    = 1'b1;
        MemAddr  = w_lane_addr;
        MemWData = {{23{r_wdata[r_lane][8]}}, r_wdata[r_lane]};
        if (w_last_lane) w_next_state = DONE;
      end
      LOAD: begin
        StallM  = 1'b1;
        MemAddr = w_lane_addr;
        if (w_last_lane) w_next_state = LOAD_LAST;
      end
      LOAD_LAST: begin
        StallM       = 1'b1;
        w_next_state = DONE;
      end
      DONE: begin
        VDone        = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    // The accept-stall looks straight at the request inputs, so it must be masked by reset too.
    if (!reset) StallM = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_lane  <= 4'd0;
      r_base  <= 32'd0;
      for (int i = 0; i < 9; i++) begin
        r_wdata[i] <= '0;
        r_rdata[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_base <= ALUResultM;
            r_lane <= 4'd0;
            for (int i = 0; i < 9; i++) r_wdata[i] <= WriteDataVM[i];
          end
        end
        STORE: begin
          r_lane <= w_last_lane ? 4'd0 : r_lane + 4'd1;
        end
        LOAD: begin
          // Read data trails its address by one cycle.
          if (r_lane != 4'd0) r_rdata[r_lane - 4'd1] <= MemRData[8:0];
          r_lane <= w_last_lane ? 4'd0 : r_lane + 4'd1;
        end
        LOAD_LAST: begin
          r_rdata[8] <= MemRData[8:0];
        end
        default: ;
      endcase
    end
  end

endmodule
